// File: rtl/uart_slave_if.sv
// Bus-side port bundle for uart_slave: write data/address/enable in, registered read data out.
interface uart_slave_if #(
    parameter int DW = 16,
    parameter int AW = 12
);
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;

    modport master (output din, addr, we, input dout);
    modport slave  (input din, addr, we, output dout);
endinterface

// File: rtl/uart_slave.sv
// uart_slave: memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor, status/control and interrupt pulse.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop in both directions.
module uart_slave #(
    parameter int          DW      = 16,
    parameter int          AW      = 12,
    parameter int          FIFO_AW = 3,
    parameter logic [15:0] DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    uart_slave_if.slave bus,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        intp_uart
);
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    localparam int unsigned      DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] ONE_CNT  = {{FIFO_AW{1'b0}}, 1'b1};

    logic        wr_data, wr_stat, wr_baud, wr_ctrl, wr_pop;
    logic [15:0] baud, div_eff;
    logic        rx_ie, txe_ie, flush_q;
    logic        ovr, ferr, perr;
    logic        set_ovr, set_ferr;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[AW-1:3];
    assign wr_data = bus.we && (bus.addr[2:0] == 3'd0);
    assign wr_stat = bus.we && (bus.addr[2:0] == 3'd1);
    assign wr_baud = bus.we && (bus.addr[2:0] == 3'd2);
    assign wr_ctrl = bus.we && (bus.addr[2:0] == 3'd3);
    assign wr_pop  = bus.we && (bus.addr[2:0] == 3'd4);
    assign div_eff = (baud < 16'd2) ? 16'd2 : baud;

    // ---------------- TX FIFO ----------------
    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_cnt;
    logic               tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_data && !tx_full && !flush_q;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.din[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else if (flush_q) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + FIFO_AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + FIFO_AW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + ONE_CNT;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - ONE_CNT;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_cnt;
    logic               rx_full, rx_empty, rx_done, rx_push, rx_pop;
    logic [7:0]         rx_sh;

    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = rx_done && !flush_q;
    assign rx_pop   = wr_pop && !rx_empty && !flush_q;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else if (flush_q) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + FIFO_AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + FIFO_AW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + ONE_CNT;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - ONE_CNT;
        end
    end

    // ---------------- TX engine ----------------
    state_t      tx_state, tx_next;
    logic [15:0] tx_div, tx_tmr;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_tick, tx_line;
`ifdef UART_PARITY_EN
    logic        tx_par;
`endif

    // Popping straight from STOP keeps back-to-back frames gapless.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        tx_tick = (tx_tmr == tx_div - 16'd1);
        case (tx_state)
            S_IDLE: begin
                if (!tx_empty && !flush_q) begin
                    tx_pop  = 1'b1;
                    tx_next = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_sh[0];
                if (tx_tick && tx_bit == 3'd7) tx_next = S_AFTER_DATA;
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_line = tx_par;
                if (tx_tick) tx_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty && !flush_q) begin
                        tx_pop  = 1'b1;
                        tx_next = S_START;
                    end else begin
                        tx_next = S_IDLE;
                    end
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_div   <= DIV_RST;
            tx_tmr   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_next;
            uart_tx  <= tx_line;
            if (tx_pop) begin
                tx_sh  <= tx_mem[tx_rp];
                tx_div <= div_eff;
                tx_tmr <= '0;
                tx_bit <= '0;
`ifdef UART_PARITY_EN
                tx_par <= ^tx_mem[tx_rp];
`endif
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_tmr <= '0;
                    if (tx_state == S_DATA) begin
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_bit <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_tmr <= tx_tmr + 16'd1;
                end
            end
        end
    end

    // ---------------- RX engine ----------------
    state_t      rx_state, rx_next;
    logic        rx_meta, rx_s, rx_prev;
    logic [15:0] rx_div, rx_tmr;
    logic [2:0]  rx_bit;
    logic        rx_tick, rx_half;
`ifdef UART_PARITY_EN
    logic        rx_par, set_perr;
`endif

    always_comb begin
        rx_next  = rx_state;
        rx_done  = 1'b0;
        set_ferr = 1'b0;
        set_ovr  = 1'b0;
`ifdef UART_PARITY_EN
        set_perr = 1'b0;
`endif
        rx_tick  = (rx_tmr == rx_div - 16'd1);
        rx_half  = (rx_tmr == (rx_div >> 1) - 16'd1);
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_AFTER_DATA;
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_tick) rx_next = S_STOP;
`endif
            S_STOP: begin
                if (rx_tick) begin
                    rx_next = S_IDLE;
                    if (!rx_s) set_ferr = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_par != ^rx_sh) set_perr = 1'b1;
`endif
                    else if (rx_full) set_ovr = 1'b1;
                    else rx_done = 1'b1;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_div   <= DIV_RST;
            rx_tmr   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
`ifdef UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            case (rx_state)
                S_IDLE: begin
                    rx_tmr <= '0;
                    rx_bit <= '0;
                    if (rx_next == S_START) rx_div <= div_eff;
                end
                S_START: rx_tmr <= rx_half ? '0 : rx_tmr + 16'd1;
                default: begin
                    rx_tmr <= rx_tick ? '0 : rx_tmr + 16'd1;
                    if (rx_tick && rx_state == S_DATA) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                    end
`ifdef UART_PARITY_EN
                    if (rx_tick && rx_state == S_PARITY) rx_par <= rx_s;
`endif
                end
            endcase
        end
    end

    // ---------------- registers, flags, interrupt, read port ----------------
    logic          irq_d;
    logic [15:0]   stat;
    logic [DW-1:0] rd;

    assign irq_d = (rx_ie && rx_push) ||
                   (txe_ie && tx_pop && !tx_push && tx_cnt == ONE_CNT);
    assign stat  = {8'h00, (tx_state != S_IDLE), perr, ferr, ovr,
                    rx_full, rx_empty, tx_empty, tx_full};

`ifndef UART_PARITY_EN
    assign perr = 1'b0;
`endif

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud      <= DIV_RST;
            rx_ie     <= 1'b0;
            txe_ie    <= 1'b0;
            flush_q   <= 1'b0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
            intp_uart <= 1'b0;
`ifdef UART_PARITY_EN
            perr      <= 1'b0;
`endif
        end else begin
            flush_q   <= wr_ctrl && bus.din[2];
            intp_uart <= irq_d;
            if (wr_baud) baud <= bus.din[15:0];
            if (wr_ctrl) begin
                rx_ie  <= bus.din[0];
                txe_ie <= bus.din[1];
            end
            ovr  <= set_ovr  | (ovr  & ~(wr_stat & bus.din[4]));
            ferr <= set_ferr | (ferr & ~(wr_stat & bus.din[5]));
`ifdef UART_PARITY_EN
            perr <= set_perr | (perr & ~(wr_stat & bus.din[6]));
`endif
        end
    end

    always_comb begin
        rd = '0;
        case (bus.addr[2:0])
            3'd0:    if (!rx_empty) rd = DW'(rx_mem[rx_rp]);
            3'd1:    rd = DW'(stat);
            3'd2:    rd = DW'(baud);
            3'd3:    rd = DW'({txe_ie, rx_ie});
            default: rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.dout <= '0;
        else      bus.dout <= rd;
    end
endmodule

// File: tb/tb_uart_slave.sv
// Self-checking bench for uart_slave: TX frames decoded against a scoreboard queue, RX bytes checked on readout.
module tb_uart_slave;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx, uart_tx, intp_uart;
    logic loop = 1'b0;
    logic drv_rx = 1'b1;
    logic mon_en = 1'b0;
    int   cur_div = 434;
    int   tx_frames = 0;
    int   irq_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always #5 clk = ~clk;

    uart_slave_if #(.DW(16), .AW(12)) bus_if ();

    assign uart_rx = loop ? uart_tx : drv_rx;

    uart_slave #(.DW(16), .AW(12), .FIFO_AW(3), .DIV_RST(16'd434)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .intp_uart (intp_uart)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    // Bus tasks are entered and left on a falling clock edge.
    task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
        bus_if.addr = a;
        bus_if.din  = d;
        bus_if.we   = 1'b1;
        @(negedge clk);
        bus_if.we   = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
        bus_if.addr = a;
        bus_if.we   = 1'b0;
        @(negedge clk);
        d = bus_if.dout;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_frames", tx_frames, target);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [10:0] f;
        f = frame_of(b);
        f[NB-1] = stop;
        for (int i = 0; i < NB; i++) begin
            drv_rx = f[i];
            repeat (cur_div) @(negedge clk);
        end
        drv_rx = 1'b1;
    endtask

    always @(negedge clk) if (intp_uart) irq_cnt++;

    initial begin : tx_monitor
        logic        prev, s, stable;
        logic [10:0] cap;
        int          d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_tx) begin
                d = cur_div;
                cap = '0;
                stable = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < d; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        s = uart_tx;
                        if (c == 0) cap[b] = s;
                        else if (s != cap[b]) stable = 1'b0;
                    end
                end
                check("tx_bit_timing", stable, 1'b1);
                check("tx_pending", tx_exp.size() > 0, 1'b1);
                if (tx_exp.size() > 0) check("tx_frame", cap, frame_of(tx_exp.pop_front()));
                tx_frames++;
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int f0, busy;
        bus_if.addr = '0;
        bus_if.din  = '0;
        bus_if.we   = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_irq", intp_uart, 1'b0);
        check("rst_dout", bus_if.dout, 16'h0000);
        bus_read(12'h001, d); check("rst_stat", d, 16'h0006);
        bus_read(12'hA02, d); check("rst_baud_alias", d, 16'd434);

        // Reset in the middle of a frame.
        bus_write(12'h000, 16'h005A);
        repeat (10) @(negedge clk);
        check("pre_rst_tx", uart_tx, 1'b0);
        #2 rst = 1'b0;
        #1 check("rst_async_tx", uart_tx, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(12'h001, d); check("rst2_stat", d, 16'h0006);
        bus_read(12'h002, d); check("rst2_baud", d, 16'd434);
        mon_en = 1'b1;

        // Same-cycle write and read of BAUD returns the old value.
        bus_write(12'h002, 16'd4);
        check("rd_before_wr", bus_if.dout, 16'd434);
        bus_read(12'h002, d); check("baud_wr", d, 16'd4);
        cur_div = 4;

        // Basic TX of 0xA5 with busy window measured through STAT.
        f0 = tx_frames;
        tx_exp.push_back(8'hA5);
        bus_write(12'h000, 16'h00A5);
        bus_if.addr = 12'h001;
        busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus_if.dout[7]) busy++;
        end
        check("tx_busy_cycles", busy, NB * 4);
        wait_tx(f0 + 1, 100);

        // Divisor below 2 behaves as 2.
        bus_write(12'h002, 16'd0);
        cur_div = 2;
        f0 = tx_frames;
        tx_exp.push_back(8'h81);
        bus_write(12'h000, 16'h0081);
        wait_tx(f0 + 1, 60);
        bus_read(12'h002, d); check("baud_zero_rd", d, 16'd0);
        bus_write(12'h002, 16'd4);
        cur_div = 4;

        // Loopback receive with rx interrupt.
        loop = 1'b1;
        bus_write(12'h003, 16'h0001);
        irq_cnt = 0;
        f0 = tx_frames;
        tx_exp.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        bus_write(12'h000, 16'h003C);
        wait_tx(f0 + 1, 100);
        repeat (20) @(negedge clk);
        check("lb_irq", irq_cnt, 1);
        bus_read(12'h000, d); check("lb_data", d, 16'(rx_exp.pop_front()));
        bus_write(12'h004, 16'h0000);
        bus_read(12'h001, d); check("lb_stat_after_pop", d, 16'h0006);

        // Overflow: nine loopback frames with no pops.
        irq_cnt = 0;
        f0 = tx_frames;
        for (int i = 1; i <= 9; i++) begin
            tx_exp.push_back(8'(i));
            if (i <= 8) rx_exp.push_back(8'(i));
            bus_write(12'h000, 16'(i));
        end
        wait_tx(f0 + 9, 9 * NB * 4 + 100);
        repeat (20) @(negedge clk);
        bus_read(12'h001, d); check("ovr_stat", d, 16'h001A);
        check("ovr_irq", irq_cnt, 8);
        bus_read(12'h000, d); check("ovr_head", d, 16'(rx_exp[0]));
        bus_write(12'h001, 16'h0010);
        bus_read(12'h001, d); check("ovr_clear", d, 16'h000A);
        for (int i = 0; i < 8; i++) begin
            bus_read(12'h000, d); check("rx_drain", d, 16'(rx_exp.pop_front()));
            bus_write(12'h004, 16'h0000);
        end
        bus_read(12'h001, d); check("drain_stat", d, 16'h0006);
        loop = 1'b0;

        // Framing error: stop bit driven low.
        irq_cnt = 0;
        drive_rx(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        bus_read(12'h001, d); check("ferr_stat", d, 16'h0026);
        check("ferr_irq", irq_cnt, 0);
        bus_write(12'h001, 16'h0020);
        bus_read(12'h001, d); check("ferr_clear", d, 16'h0006);

        // Start-bit glitch is ignored, then a clean frame is received.
        drv_rx = 1'b0;
        @(negedge clk);
        drv_rx = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(12'h001, d); check("glitch_stat", d, 16'h0006);
        rx_exp.push_back(8'h96);
        drive_rx(8'h96, 1'b1);
        repeat (10) @(negedge clk);
        check("rx_drv_irq", irq_cnt, 1);
        bus_read(12'h000, d); check("rx_drv_data", d, 16'(rx_exp.pop_front()));
        bus_write(12'h004, 16'h0000);

        // TX FIFO full while the engine is busy, then one empty interrupt.
        bus_write(12'h003, 16'h0002);
        f0 = tx_frames;
        tx_exp.push_back(8'h11);
        bus_write(12'h000, 16'h0011);
        repeat (8) @(negedge clk);
        irq_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_exp.push_back(8'hC0 + 8'(i));
            bus_write(12'h000, 16'h00C0 + 16'(i));
        end
        bus_read(12'h001, d); check("txfull_stat", d, 16'h0085);
        wait_tx(f0 + 9, 9 * NB * 4 + 100);
        repeat (50) @(negedge clk);
        check("tx_no_extra", tx_frames, f0 + 9);
        check("txe_irq", irq_cnt, 1);
        bus_read(12'h001, d); check("final_stat", d, 16'h0006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_slave.md
Name: uart_slave

Overview:
- Memory-mapped UART peripheral on the 16-bit data bus.
- Occupies one 4 KB block slot; the bus decoder strips the top 4 address bits before they reach this block.
- Contains TX and RX FIFOs, a programmable baud divisor, status/control registers, and a single-cycle interrupt pulse to the interrupt controller's external input.
- Frame format: 8N1, LSB first.

Parameters:
- DW, 16, bus data width.
- AW, 12, block-local address width.
- FIFO_AW, 3, log2 FIFO depth; default depth is 8 entries per direction.
- DIV_RST, 16'd434, reset baud divisor in clk cycles per bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0); all state cleared while low.
- din  input  DW  write data from bus.
- addr  input  AW  block-local address; only addr[2:0] decoded, higher bits alias.
- we  input  1  write enable, active high, sampled at posedge clk.
- dout  output  DW  registered read data.
- uart_rx  input  1  serial receive line (asynchronous).
- uart_tx  output  1  serial transmit line.
- intp_uart  output  1  interrupt pulse, one clk wide.

Behaviour:
- Reset values: dout=0, uart_tx=1, intp_uart=0, both FIFOs empty, BAUD=DIV_RST, CTRL=0, sticky flags=0.
- Read timing:
  - dout is loaded at every posedge from the register selected by addr; read latency is 1 cycle.
  - No read strobe exists, so reads have no side effects.
  - A same-cycle write and read of one register returns the pre-write value.
- Register map (addr[2:0]):
  - 0 DATA
    - Write pushes din[7:0] to the TX FIFO; ignored if the FIFO is full.
    - Read returns {8'h0, RX FIFO head}, or 0 if the RX FIFO is empty.
  - 1 STAT
    - Bits: [0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]ovr [5]ferr [6]perr [7]tx_busy; [15:8]=0.
    - Writing 1 to bits 4-6 clears the corresponding flag. If set and clear coincide, set wins.
  - 2 BAUD
    - Holds the divisor. Values <2 are treated as 2.
    - Each engine latches the divisor at the start of a frame, so a mid-frame write takes effect on the next frame.
  - 3 CTRL
    - [0]rx_ie, [1]txe_ie.
    - [2]flush, self-clearing: empties both FIFOs next cycle. A frame already being shifted completes.
    - Reads return flush as 0.
  - 4 RXPOP: any write pops the RX head; ignored if empty.
  - 5-7: reads return 0; writes ignored.
- FIFO rules:
  - Simultaneous push and pop on a non-empty FIFO performs both; occupancy is unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
  - An occupancy counter of FIFO_AW+1 bits distinguishes full from empty.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the FIFO is not empty, pop it into the shifter, latch the divisor, go to START.
  - START: uart_tx=0 for DIV cycles.
  - DATA: 8 bits LSB first, DIV cycles each.
  - STOP: uart_tx=1 for DIV cycles, then return to IDLE.
  - Back-to-back frames have no extra idle gap.
  - tx_busy=1 whenever the state is not IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchronizer (rx_s).
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on rx_s latches the divisor and goes to START.
  - START: wait DIV/2 cycles. If rx_s=1, treat as a glitch and return to IDLE; else go to DATA.
  - DATA: sample every DIV cycles, 8 bits.
  - STOP: sample after DIV cycles.
    - rx_s=0: set ferr, discard the byte.
    - Else if the RX FIFO is full: set ovr, discard the byte.
    - Else push the byte.
  - Return to IDLE in all cases.
- Interrupt:
  - intp_uart=1 for exactly one cycle when (rx_ie and RX push) or (txe_ie and TX occupancy goes 1->0).
  - The pulse follows the triggering edge by one register stage.
- Reset mid-frame: uart_tx goes to 1 immediately (asynchronous), the partial frame is lost, and both FSMs go to IDLE.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - An even-parity bit is inserted between DATA and STOP on both TX and RX, using a PARITY state.
  - On RX parity mismatch: set perr and discard the byte. A stop-bit error takes precedence as ferr only.
- When undefined:
  - Frame is 8N1, no PARITY state.
  - STAT[6] reads 0 and clearing it has no effect.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 mid-transmission, release.
  - Required: uart_tx=1, STAT reads 16'h0006, BAUD reads 434.
- Basic TX:
  - Stimulus: BAUD=4; write DATA=8'hA5.
  - Required: uart_tx shows 0 then bits 1,0,1,0,0,1,0,1, then 1, each 4 cycles; tx_busy is high for exactly 40 cycles.
- Loopback RX:
  - Stimulus: tie uart_tx to uart_rx, rx_ie=1, send 8'h3C.
  - Required: one intp_uart pulse; DATA reads 16'h003C; write RXPOP, then STAT[2]=1.
- Overflow:
  - Stimulus: loopback; push 9 bytes 8'h01..8'h09 with no pops.
  - Required: STAT[3]=1 and STAT[4]=1; DATA head=8'h01; 8'h09 lost; writing STAT=16'h0010 clears ovr.
- Framing error:
  - Stimulus: drive a frame on uart_rx with stop bit 0.
  - Required: ferr=1, RX FIFO stays empty, no interrupt.
- TX FIFO full and empty interrupt:
  - Stimulus: txe_ie=1; write 9 bytes in consecutive cycles.
  - Required: 9th byte ignored; exactly 8 frames sent; single intp_uart pulse when the last byte leaves the FIFO.
